if_id_register: RTL

Pipeline register between instruction fetch and decode in the 5-stage MIPS core. It captures the fetched instruction word and its PC+4 value each cycle. It holds them on a decode stall and replaces them with a NOP bubble on a flush. It also keeps two saturating event counters (stall cycles, flushes) that the debug path can read.

---
 rtl/if_id_if.sv | 26 ++
 rtl/if_id_register.sv | 51 +++++
 2 files changed

// File: rtl/if_id_if.sv
// Fetch-to-decode pipeline bundle: fetch-side inputs, hazard controls, decode-side outputs
// and the debug event counters.
interface if_id_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] adder_pc_4;
   logic [WIDTH-1:0] if_instruction;
   logic             if_valid;
   logic             stall;
   logic             flush;
   logic [WIDTH-1:0] id_pc_4;
   logic [WIDTH-1:0] id_instruction;
   logic             id_valid;
   logic [31:0]      stall_count;
   logic [31:0]      flush_count;

   modport master (
      output adder_pc_4, if_instruction, if_valid, stall, flush,
      input  id_pc_4, id_instruction, id_valid, stall_count, flush_count
   );

   modport slave (
      input  adder_pc_4, if_instruction, if_valid, stall, flush,
      output id_pc_4, id_instruction, id_valid, stall_count, flush_count
   );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load, hold on stall, bubble on flush, plus saturating
// stall/flush event counters for the debug path.
module if_id_register #(
   parameter int             WIDTH = 32,
   parameter logic [WIDTH-1:0] NOP = '0
) (
   input logic   clk,
   input logic   rst,
   if_id_if.slave bus
);
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] instr_q;
   logic             valid_q;
   logic [31:0]      stall_cnt;
   logic [31:0]      flush_cnt;

   // Flush outranks stall so a taken branch never leaves a held wrong-path instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         instr_q <= NOP;
         valid_q <= 1'b0;
      end else if (bus.flush) begin
         pc_q    <= '0;
         instr_q <= NOP;
         valid_q <= 1'b0;
      end else if (!bus.stall) begin
         pc_q    <= bus.adder_pc_4;
         instr_q <= bus.if_valid ? bus.if_instruction : NOP;
         valid_q <= bus.if_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (bus.flush && (flush_cnt != 32'hFFFF_FFFF))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign bus.id_pc_4        = pc_q;
   assign bus.id_instruction = instr_q;
   assign bus.id_valid       = valid_q;
   assign bus.stall_count    = stall_cnt;
   assign bus.flush_count    = flush_cnt;
endmodule
